// File: rtl/irq_controller.sv
// Multi-channel edge-captured interrupt controller feeding the processor ExtIRQ/ExtIAck pins.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchronizer per channel ahead of edge detection.
module irq_controller #(
    parameter int              N_CH       = 8,
    parameter int              N          = 64,
    parameter logic [N-1:0]    CAUSE_BASE = 64'h10,
    parameter logic [N_CH-1:0] MASK_RST   = '1
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [N_CH-1:0]         irq_in,
    input  logic                    mask_we,
    input  logic [N_CH-1:0]         mask_wdata,
    input  logic                    ExtIAck,
    input  logic                    eoi,
    output logic                    ExtIRQ,
    output logic [$clog2(N_CH)-1:0] irq_id,
    output logic [N-1:0]            irq_cause,
    output logic [N_CH-1:0]         pending,
    output logic [N_CH-1:0]         mask,
    output logic                    busy
);

    localparam int ID_W = $clog2(N_CH);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } stateT;

    stateT           state;
    stateT           stateNext;
    logic [N_CH-1:0] edgeSrc;
    logic [N_CH-1:0] prev;
    logic [N_CH-1:0] riseEdge;
    logic [N_CH-1:0] eligible;
    logic [N_CH-1:0] clrVec;
    logic [ID_W-1:0] winner;
    logic            latchId;
    logic            ackFire;

    function automatic logic [ID_W-1:0] lowestSet(input logic [N_CH-1:0] v);
        lowestSet = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i]) lowestSet = ID_W'(i);
        end
    endfunction

`ifdef IRQ_SYNC_EN
    logic [N_CH-1:0] irqSync_p0;
    logic [N_CH-1:0] irqSync_p1;

    // Synchronizer stages p0 -> p1
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            irqSync_p0 <= '0;
            irqSync_p1 <= '0;
        end else begin
            irqSync_p0 <= irq_in;
            irqSync_p1 <= irqSync_p0;
        end
    end

    assign edgeSrc = irqSync_p1;
`else
    assign edgeSrc = irq_in;
`endif

    assign riseEdge  = edgeSrc & ~prev;
    assign eligible  = pending & mask;
    assign winner    = lowestSet(eligible);
    assign irq_cause = CAUSE_BASE + N'(irq_id);

    always_comb begin
        clrVec = '0;
        for (int i = 0; i < N_CH; i++) begin
            clrVec[i] = ackFire && (irq_id == ID_W'(i));
        end
    end

    // A new edge on the channel being acked wins over the clear
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            prev    <= '0;
            pending <= '0;
            mask    <= MASK_RST;
            irq_id  <= '0;
        end else begin
            prev    <= edgeSrc;
            pending <= (pending & ~clrVec) | riseEdge;
            if (mask_we) mask <= mask_wdata;
            if (latchId) irq_id <= winner;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (|eligible) stateNext = REQ;
            REQ: begin
                if (ExtIAck)            stateNext = SERVICE;
                else if (!mask[irq_id]) stateNext = IDLE;
            end
            SERVICE: if (eoi) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // ExtIRQ and busy decode straight from the state flops
    always_comb begin
        ExtIRQ  = (state == REQ);
        busy    = (state == SERVICE);
        latchId = (state == IDLE) && (|eligible);
        ackFire = (state == REQ) && ExtIAck;
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed-vector bench for irq_controller; honours IRQ_SYNC_EN for the latency it expects.
module tb_irq_controller;

    localparam int N_CH = 8;
    localparam int N    = 64;
`ifdef IRQ_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif
    localparam int LAT = SYNC_DLY + 2;

    logic                    CLOCK_50 = 1'b0;
    logic                    reset    = 1'b1;
    logic [N_CH-1:0]         irq_in   = '0;
    logic                    mask_we  = 1'b0;
    logic [N_CH-1:0]         mask_wdata = '0;
    logic                    ExtIAck  = 1'b0;
    logic                    eoi      = 1'b0;
    logic                    ExtIRQ;
    logic [$clog2(N_CH)-1:0] irq_id;
    logic [N-1:0]            irq_cause;
    logic [N_CH-1:0]         pending;
    logic [N_CH-1:0]         mask;
    logic                    busy;

    int testCount = 0;
    int failCount = 0;

    irq_controller #(
        .N_CH      (N_CH),
        .N         (N),
        .CAUSE_BASE(64'h10),
        .MASK_RST  (8'hFF)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .irq_in    (irq_in),
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .ExtIAck   (ExtIAck),
        .eoi       (eoi),
        .ExtIRQ    (ExtIRQ),
        .irq_id    (irq_id),
        .irq_cause (irq_cause),
        .pending   (pending),
        .mask      (mask),
        .busy      (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [N_CH-1:0] v);
        irq_in = v;
        tick(1);
        irq_in = '0;
    endtask

    task automatic doAck();
        ExtIAck = 1'b1;
        tick(1);
        ExtIAck = 1'b0;
    endtask

    task automatic doEoi();
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
    endtask

    task automatic writeMask(input logic [N_CH-1:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        tick(1);
        mask_we    = 1'b0;
    endtask

    initial begin
        // Reset values
        tick(2);
        check("rst_extirq", 64'(ExtIRQ), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_pending", 64'(pending), 64'h0);
        check("rst_mask", 64'(mask), 64'hFF);
        check("rst_id", 64'(irq_id), 64'h0);
        check("rst_cause", irq_cause, 64'h10);
        reset = 1'b0;
        tick(1);

        // Single edge on channel 3
        pulse(8'h08);
        tick(LAT - 2);
        check("single_pend", 64'(pending), 64'h08);
        check("single_noreq_yet", 64'(ExtIRQ), 64'h0);
        tick(1);
        check("single_req", 64'(ExtIRQ), 64'h1);
        check("single_id", 64'(irq_id), 64'h3);
        check("single_cause", irq_cause, 64'h13);
        tick(2);
        check("single_hold", 64'(ExtIRQ), 64'h1);
        doAck();
        check("single_ack_req", 64'(ExtIRQ), 64'h0);
        check("single_ack_pend", 64'(pending), 64'h0);
        check("single_ack_busy", 64'(busy), 64'h1);
        check("single_svc_id", 64'(irq_id), 64'h3);
        doEoi();
        check("single_eoi_busy", 64'(busy), 64'h0);
        check("single_eoi_req", 64'(ExtIRQ), 64'h0);

        // Priority: channels 5 and 2 together
        pulse(8'h24);
        tick(LAT - 1);
        check("prio_req", 64'(ExtIRQ), 64'h1);
        check("prio_id_first", 64'(irq_id), 64'h2);
        check("prio_pend", 64'(pending), 64'h24);
        doAck();
        check("prio_ack_pend", 64'(pending), 64'h20);
        check("prio_ack_busy", 64'(busy), 64'h1);
        doEoi();
        check("prio_eoi_req", 64'(ExtIRQ), 64'h0);
        tick(1);
        check("prio_rereq", 64'(ExtIRQ), 64'h1);
        check("prio_id_second", 64'(irq_id), 64'h5);
        check("prio_cause", irq_cause, 64'h15);
        doEoi();
        check("eoi_in_req_req", 64'(ExtIRQ), 64'h1);
        check("eoi_in_req_busy", 64'(busy), 64'h0);
        doAck();
        doEoi();
        check("prio_clean", 64'(pending), 64'h0);

        // Masking
        writeMask(8'hFB);
        check("mask_write", 64'(mask), 64'hFB);
        pulse(8'h04);
        tick(LAT - 2);
        tick(2);
        check("mask_pend", 64'(pending), 64'h04);
        check("mask_noreq", 64'(ExtIRQ), 64'h0);
        writeMask(8'hFF);
        check("unmask_edge_w", 64'(ExtIRQ), 64'h0);
        tick(1);
        check("unmask_req", 64'(ExtIRQ), 64'h1);
        check("unmask_id", 64'(irq_id), 64'h2);
        doAck();
        doEoi();

        // Withdraw of channel 4 by masking while in REQ
        pulse(8'h10);
        tick(LAT - 1);
        check("wd_req", 64'(ExtIRQ), 64'h1);
        check("wd_id", 64'(irq_id), 64'h4);
        writeMask(8'hEF);
        check("wd_still_req", 64'(ExtIRQ), 64'h1);
        tick(1);
        check("wd_dropped", 64'(ExtIRQ), 64'h0);
        check("wd_idle_busy", 64'(busy), 64'h0);
        check("wd_pend_kept", 64'(pending), 64'h10);
        doAck();
        check("ack_idle_pend", 64'(pending), 64'h10);
        check("ack_idle_busy", 64'(busy), 64'h0);
        check("ack_idle_req", 64'(ExtIRQ), 64'h0);
        writeMask(8'hFF);
        tick(1);
        check("wd_rereq", 64'(ExtIRQ), 64'h1);
        check("wd_reid", 64'(irq_id), 64'h4);
        doAck();
        doEoi();
        check("wd_clean", 64'(pending), 64'h0);

        // Set wins over clear on channel 1
        pulse(8'h02);
        tick(LAT - 1);
        check("col_req", 64'(ExtIRQ), 64'h1);
        check("col_id", 64'(irq_id), 64'h1);
        irq_in = 8'h02;
        tick(SYNC_DLY);
        ExtIAck = 1'b1;
        tick(1);
        ExtIAck = 1'b0;
        irq_in  = '0;
        check("col_pend_set", 64'(pending), 64'h02);
        check("col_busy", 64'(busy), 64'h1);
        check("col_ack_req", 64'(ExtIRQ), 64'h0);
        doEoi();
        check("col_eoi_req", 64'(ExtIRQ), 64'h0);
        tick(1);
        check("col_second_req", 64'(ExtIRQ), 64'h1);
        check("col_second_id", 64'(irq_id), 64'h1);
        doAck();
        doEoi();
        check("col_clean", 64'(pending), 64'h0);

        // Reset in SERVICE with pending 0x81 (also: no preemption of REQ)
        pulse(8'h02);
        tick(LAT - 1);
        pulse(8'h81);
        tick(LAT - 1);
        check("nopre_pend", 64'(pending), 64'h83);
        check("nopre_id", 64'(irq_id), 64'h1);
        check("nopre_req", 64'(ExtIRQ), 64'h1);
        doAck();
        check("svc_pend", 64'(pending), 64'h81);
        check("svc_busy", 64'(busy), 64'h1);
        writeMask(8'h7F);
        check("svc_mask", 64'(mask), 64'h7F);
        reset = 1'b1;
        #1;
        check("arst_req", 64'(ExtIRQ), 64'h0);
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_pend", 64'(pending), 64'h0);
        check("arst_mask", 64'(mask), 64'hFF);
        check("arst_id", 64'(irq_id), 64'h0);
        tick(2);
        reset = 1'b0;
        tick(LAT + 2);
        check("post_rst_req", 64'(ExtIRQ), 64'h0);
        check("post_rst_pend", 64'(pending), 64'h0);

        // Input already high at reset release counts as one edge
        reset  = 1'b1;
        irq_in = 8'h01;
        tick(1);
        reset = 1'b0;
        tick(LAT - 1);
        check("hi_rel_pend", 64'(pending), 64'h01);
        check("hi_rel_noreq", 64'(ExtIRQ), 64'h0);
        tick(1);
        check("hi_rel_req", 64'(ExtIRQ), 64'h1);
        check("hi_rel_id", 64'(irq_id), 64'h0);
        check("hi_rel_cause", irq_cause, 64'h10);
        irq_in = '0;

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Parametrised multi-channel external interrupt controller for the ARM single-cycle processor. It replaces the single ExtIRQ line driven directly by the bench. It captures rising edges on N_CH external request lines, applies a software mask, and selects the highest-priority pending channel (lowest index). It presents that channel to the processor on ExtIRQ with an id and exception-cause code, then tracks the ack / end-of-interrupt handshake. It sits between the external request sources and the processor's ExtIRQ/ExtIAck pins in processor_arm.

## Interface
- N_CH, 8: number of request channels (2..32)
- N, 64: width of the cause word (processor register width)
- CAUSE_BASE, 64'h10: cause code for channel 0; channel i reports CAUSE_BASE + i
- MASK_RST, all ones: mask register value after reset (1 = channel enabled)

Ports:
- CLOCK_50  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- irq_in  in  N_CH  raw external requests, rising-edge sensitive
- mask_we  in  1  mask register write strobe
- mask_wdata  in  N_CH  new mask value
- ExtIAck  in  1  processor acknowledge, one-cycle pulse
- eoi  in  1  end of interrupt from processor (ERET), one-cycle pulse
- ExtIRQ  out  1  interrupt request to processor (registered)
- irq_id  out  $clog2(N_CH)  channel being presented or serviced
- irq_cause  out  N  CAUSE_BASE + irq_id, zero-extended
- pending  out  N_CH  pending register
- mask  out  N_CH  mask register
- busy  out  1  high in SERVICE

## Operation
- Edge capture: prev register holds the last sampled irq_in. pending[i] is set when irq_in[i] is 1 and prev[i] is 0. Pending bits set regardless of mask. Masked bits are held but never selected.
- Selection: eligible = pending & mask. Winner = lowest set index of eligible.
- FSM states:
  - IDLE: if eligible is non-zero, latch the winner into irq_id, set ExtIRQ to 1, go to REQ. Otherwise stay.
  - REQ: hold ExtIRQ=1 and irq_id stable.
    - If ExtIAck=1: clear pending[irq_id], set ExtIRQ to 0, go to SERVICE.
    - Otherwise, if mask[irq_id] has become 0: set ExtIRQ to 0, go to IDLE, pending bit kept.
    - A newly pending higher-priority channel does not preempt REQ.
  - SERVICE: busy=1, ExtIRQ=0, irq_id held. eoi=1 returns to IDLE. No nesting.
- ExtIAck outside REQ is ignored. eoi outside SERVICE is ignored.
- Same-cycle set and clear on one channel (new edge while that channel is acked): set wins, and the bit stays 1.
- Mask write takes effect at the next edge. The new mask is used by IDLE selection and by the REQ withdraw check on the following cycle.
- irq_cause is combinational from irq_id: CAUSE_BASE + irq_id, with N-bit wrap.

## Timing
- Reset values (asynchronous): state IDLE, ExtIRQ 0, irq_id 0, busy 0, pending 0, prev 0, mask MASK_RST, sync flops 0.
- Because prev resets to 0, an input already high when reset releases is captured as one edge on the first clock.
- Reset asserted mid-handshake forces all of the above immediately. In-flight requests are lost.
- Latency, edge to request: irq_in first sampled high at edge k gives pending=1 after edge k and ExtIRQ=1 after edge k+1 (2 cycles).
- Acknowledge: ExtIAck sampled at edge m in REQ gives ExtIRQ=0, pending cleared and busy=1 after edge m.
- End of interrupt: eoi sampled at edge p gives IDLE after p. The next ExtIRQ is asserted after edge p+1 at the earliest.
- Withdraw: a mask write at edge w that clears the REQ channel gives ExtIRQ=0 after edge w+1.

## Configuration
- IRQ_SYNC_EN defined: irq_in passes through a 2-flop synchronizer per channel before edge detection. Edge-to-ExtIRQ latency is 4 cycles. Sync flops reset to 0.
- IRQ_SYNC_EN undefined: irq_in feeds edge detection directly. Latency is 2 cycles. Inputs must be synchronous to CLOCK_50.

## Test plan
- Single edge: N_CH=8, mask all ones, pulse irq_in[3] for 1 cycle, ack 3 cycles later, then eoi. Expect ExtIRQ=1 two edges after the pulse (4 with IRQ_SYNC_EN), irq_id=3, irq_cause=64'h13. After ack: ExtIRQ=0, pending[3]=0, busy=1. After eoi: busy=0.
- Priority: edges on channels 5 and 2 in the same cycle. Expect irq_id=2 first. After ack and eoi, expect irq_id=5 with ExtIRQ re-asserted 2 edges after eoi.
- Masking: write mask=8'hFB, then pulse ch2. Expect pending[2]=1 and ExtIRQ=0. Write mask=8'hFF. Expect ExtIRQ=1, irq_id=2, one edge after the write edge.
- Withdraw: ch4 in REQ, write mask bit 4 to 0 without ack. Expect ExtIRQ=0, state IDLE, pending[4]=1. ExtIAck pulsed in IDLE has no effect.
- Set-wins collision: new irq_in[1] edge captured on the same edge as ExtIAck for ch1. Expect pending[1]=1 after that edge and a second request after eoi.
- Reset mid-operation: assert reset while in SERVICE with pending=8'h81. Expect immediately ExtIRQ=0, busy=0, pending=0, mask=8'hFF, irq_id=0. No request after release unless a new edge arrives.
